// File: rtl/count_sequence_checker_pkg.sv
// Shared types and default widths for the counter stage and its sequence checker.
package count_sequence_checker_pkg;

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    TRACK   = 2'd1,
    FAULT   = 2'd2
  } state_e;

  localparam int CNT_W  = 4;
  localparam int WRAP_W = 8;

endpackage

// File: rtl/count_sequence_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; used for the wrap statistics.
module sat_counter #(
  parameter int WRAP_W = count_sequence_checker_pkg::WRAP_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              inc_i,
  output logic [WRAP_W-1:0] cnt_o
);

  logic [WRAP_W-1:0] cnt_q;
  logic [WRAP_W-1:0] cnt_d;

  function automatic logic [WRAP_W-1:0] sat_inc(input logic [WRAP_W-1:0] v);
    return (&v) ? v : v + WRAP_W'(1);
  endfunction

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = sat_inc(cnt_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/count_sequence_checker.sv
// Monitors a free-running binary counter: locks onto +1 steps, counts wraps,
// tolerates an upstream restart at zero and latches the first sequence error.
module count_sequence_checker #(
  parameter int WIDTH    = count_sequence_checker_pkg::CNT_W,
  parameter int WRAP_W   = count_sequence_checker_pkg::WRAP_W,
  parameter int SYNC_LEN = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [WIDTH-1:0]  count_i,
  input  logic              clr_i,
  output logic              in_sync_o,
  output logic              fault_o,
  output logic [WIDTH-1:0]  fault_count_o,
  output logic [WIDTH-1:0]  expected_o,
  output logic              wrap_pulse_o,
  output logic [WRAP_W-1:0] wrap_cnt_o
);
  import count_sequence_checker_pkg::*;

  localparam int MATCH_W = $clog2(SYNC_LEN + 1);
  localparam logic [MATCH_W-1:0] LOCK_AT = MATCH_W'(SYNC_LEN - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   prev_q, prev_d;
  logic               prev_valid_q, prev_valid_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [WIDTH-1:0]   fault_count_q, fault_count_d;
  logic               wrap_pulse_q, wrap_pulse_d;
  logic               wrap_inc;
  logic [WIDTH-1:0]   prev_inc;
  logic               step_ok;
  logic               prev_max;
  logic               count_zero;

  assign prev_inc   = prev_q + WIDTH'(1);
  assign step_ok    = (count_i == prev_inc);
  assign prev_max   = &prev_q;
  assign count_zero = (count_i == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ACQUIRE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clr_i) begin
      state_d = ACQUIRE;
    end else if (prev_valid_q) begin
      case (state_q)
        ACQUIRE: if (step_ok && match_q == LOCK_AT) state_d = TRACK;
        TRACK:   if (!step_ok) state_d = count_zero ? ACQUIRE : FAULT;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    in_sync_o = (state_q == TRACK);
    fault_o   = (state_q == FAULT);
  end

  // A zero that is not a wrap means the upstream counter restarted: re-acquire.
  // On a real fault prev is left alone so expected shows what was required.
  always_comb begin
    prev_d        = prev_q;
    prev_valid_d  = prev_valid_q;
    match_d       = match_q;
    fault_count_d = fault_count_q;
    wrap_pulse_d  = 1'b0;
    wrap_inc      = 1'b0;
    if (clr_i) begin
      prev_d        = count_i;
      prev_valid_d  = 1'b1;
      match_d       = '0;
      fault_count_d = '0;
    end else if (!prev_valid_q) begin
      prev_d       = count_i;
      prev_valid_d = 1'b1;
    end else begin
      case (state_q)
        ACQUIRE: begin
          prev_d = count_i;
          if (step_ok && match_q != LOCK_AT) match_d = match_q + MATCH_W'(1);
          else                               match_d = '0;
        end
        TRACK: begin
          if (step_ok) begin
            prev_d = count_i;
            if (prev_max) begin
              wrap_pulse_d = 1'b1;
              wrap_inc     = 1'b1;
            end
          end else if (count_zero) begin
            prev_d  = count_i;
            match_d = '0;
          end else begin
            fault_count_d = count_i;
          end
        end
        default: prev_d = prev_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q        <= '0;
      prev_valid_q  <= 1'b0;
      match_q       <= '0;
      fault_count_q <= '0;
      wrap_pulse_q  <= 1'b0;
    end else begin
      prev_q        <= prev_d;
      prev_valid_q  <= prev_valid_d;
      match_q       <= match_d;
      fault_count_q <= fault_count_d;
      wrap_pulse_q  <= wrap_pulse_d;
    end
  end

  sat_counter #(.WRAP_W(WRAP_W)) u_wrap_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (clr_i),
    .inc_i  (wrap_inc),
    .cnt_o  (wrap_cnt_o)
  );

  assign expected_o    = prev_inc;
  assign fault_count_o = fault_count_q;
  assign wrap_pulse_o  = wrap_pulse_q;

endmodule

// File: tb/tb_count_sequence_checker.sv
// Bench for count_sequence_checker: directed table, corner sequences and random
// stimulus compared against a sample-history reference model.
module tb_count_sequence_checker;

  localparam int SYNC = 2;

  logic       clk;
  logic       rst_n;
  logic [3:0] count;
  logic       clr;
  logic       in_sync;
  logic       fault;
  logic [3:0] fault_count;
  logic [3:0] expected;
  logic       wrap_pulse;
  logic [7:0] wrap_cnt;

  int total = 0;
  int bad   = 0;

  count_sequence_checker dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .count_i       (count),
    .clr_i         (clr),
    .in_sync_o     (in_sync),
    .fault_o       (fault),
    .fault_count_o (fault_count),
    .expected_o    (expected),
    .wrap_pulse_o  (wrap_pulse),
    .wrap_cnt_o    (wrap_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: last accepted sample, run of good steps, lock/fault flags.
  int m_prev, m_have, m_streak, m_fc, m_wraps, m_pulse;
  bit m_lock, m_fault;

  task automatic model_reset();
    m_prev = 0; m_have = 0; m_streak = 0; m_fc = 0; m_wraps = 0; m_pulse = 0;
    m_lock = 0; m_fault = 0;
  endtask

  task automatic model_step(input int c, input bit k);
    bit ok;
    m_pulse = 0;
    if (k) begin
      m_prev = c; m_have = 1; m_streak = 0; m_lock = 0; m_fault = 0;
      m_fc = 0; m_wraps = 0;
    end else if (m_have == 0) begin
      m_prev = c; m_have = 1;
    end else if (!m_fault) begin
      ok = (c == (m_prev + 1) % 16);
      if (!m_lock) begin
        m_streak = ok ? m_streak + 1 : 0;
        if (m_streak >= SYNC) begin
          m_lock = 1; m_streak = 0;
        end
        m_prev = c;
      end else if (ok) begin
        if (c == 0) begin
          m_pulse = 1;
          if (m_wraps < 255) m_wraps++;
        end
        m_prev = c;
      end else if (c == 0) begin
        m_lock = 0; m_streak = 0; m_prev = 0;
      end else begin
        m_lock = 0; m_fault = 1; m_fc = c;
      end
    end
  endtask

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".in_sync"}, int'(in_sync), int'(m_lock));
    chk({tag, ".fault"}, int'(fault), int'(m_fault));
    chk({tag, ".fault_count"}, int'(fault_count), m_fc);
    chk({tag, ".expected"}, int'(expected), (m_prev + 1) % 16);
    chk({tag, ".wrap_pulse"}, int'(wrap_pulse), m_pulse);
    chk({tag, ".wrap_cnt"}, int'(wrap_cnt), m_wraps);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".in_sync"}, int'(in_sync), 0);
    chk({tag, ".fault"}, int'(fault), 0);
    chk({tag, ".fault_count"}, int'(fault_count), 0);
    chk({tag, ".expected"}, int'(expected), 1);
    chk({tag, ".wrap_pulse"}, int'(wrap_pulse), 0);
    chk({tag, ".wrap_cnt"}, int'(wrap_cnt), 0);
  endtask

  task automatic apply(input int c, input bit k);
    count = 4'(c);
    clr   = k;
    @(posedge clk);
    model_step(c, k);
    #1;
  endtask

  typedef struct {
    logic [3:0] cnt;
    logic       clr;
    logic       sync;
    logic       flt;
    logic [3:0] fc;
    logic [3:0] exp;
    logic       pls;
    logic [7:0] wc;
  } vec_t;

  vec_t vq[$];
  int   pulses;
  int   r;

  initial begin
    rst_n = 1'b0;
    count = '0;
    clr   = 1'b0;
    model_reset();

    @(posedge clk); #1;
    check_reset("por");
    @(negedge clk);
    rst_n = 1'b1;

    // cnt clr | sync flt fc exp pls wc
    vq.push_back('{4'd0,  1'b0, 1'b0, 1'b0, 4'd0, 4'd1,  1'b0, 8'd0});
    vq.push_back('{4'd1,  1'b0, 1'b0, 1'b0, 4'd0, 4'd2,  1'b0, 8'd0});
    vq.push_back('{4'd2,  1'b0, 1'b1, 1'b0, 4'd0, 4'd3,  1'b0, 8'd0});
    vq.push_back('{4'd3,  1'b0, 1'b1, 1'b0, 4'd0, 4'd4,  1'b0, 8'd0});
    vq.push_back('{4'd4,  1'b0, 1'b1, 1'b0, 4'd0, 4'd5,  1'b0, 8'd0});
    vq.push_back('{4'd5,  1'b0, 1'b1, 1'b0, 4'd0, 4'd6,  1'b0, 8'd0});
    vq.push_back('{4'd6,  1'b0, 1'b1, 1'b0, 4'd0, 4'd7,  1'b0, 8'd0});
    vq.push_back('{4'd9,  1'b0, 1'b0, 1'b1, 4'd9, 4'd7,  1'b0, 8'd0});
    vq.push_back('{4'd10, 1'b0, 1'b0, 1'b1, 4'd9, 4'd7,  1'b0, 8'd0});
    vq.push_back('{4'd11, 1'b0, 1'b0, 1'b1, 4'd9, 4'd7,  1'b0, 8'd0});
    vq.push_back('{4'd12, 1'b1, 1'b0, 1'b0, 4'd0, 4'd13, 1'b0, 8'd0});
    vq.push_back('{4'd13, 1'b0, 1'b0, 1'b0, 4'd0, 4'd14, 1'b0, 8'd0});
    vq.push_back('{4'd14, 1'b0, 1'b1, 1'b0, 4'd0, 4'd15, 1'b0, 8'd0});
    vq.push_back('{4'd15, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0,  1'b0, 8'd0});
    vq.push_back('{4'd0,  1'b0, 1'b1, 1'b0, 4'd0, 4'd1,  1'b1, 8'd1});
    vq.push_back('{4'd1,  1'b0, 1'b1, 1'b0, 4'd0, 4'd2,  1'b0, 8'd1});

    for (int i = 0; i < vq.size(); i++) begin
      apply(int'(vq[i].cnt), vq[i].clr);
      chk($sformatf("vec%0d.in_sync", i), int'(in_sync), int'(vq[i].sync));
      chk($sformatf("vec%0d.fault", i), int'(fault), int'(vq[i].flt));
      chk($sformatf("vec%0d.fault_count", i), int'(fault_count), int'(vq[i].fc));
      chk($sformatf("vec%0d.expected", i), int'(expected), int'(vq[i].exp));
      chk($sformatf("vec%0d.wrap_pulse", i), int'(wrap_pulse), int'(vq[i].pls));
      chk($sformatf("vec%0d.wrap_cnt", i), int'(wrap_cnt), int'(vq[i].wc));
    end

    // Full pass 2..15 then 0: exactly one pulse, one more wrap.
    pulses = 0;
    for (int v = 2; v <= 16; v++) begin
      apply(v % 16, 1'b0);
      check_model("wrap");
      pulses += int'(wrap_pulse);
    end
    chk("wrap.pulses", pulses, 1);
    chk("wrap.cnt", int'(wrap_cnt), 2);
    apply(1, 1'b0);
    chk("wrap.pulse_drop", int'(wrap_pulse), 0);

    // Upstream restart: 2..8 then 0 drops lock without a fault.
    for (int v = 2; v <= 8; v++) apply(v, 1'b0);
    apply(0, 1'b0);
    check_model("ureset");
    chk("ureset.in_sync", int'(in_sync), 0);
    chk("ureset.fault", int'(fault), 0);
    apply(1, 1'b0);
    chk("ureset.sync1", int'(in_sync), 0);
    apply(2, 1'b0);
    chk("ureset.sync2", int'(in_sync), 1);

    // clr on the wrapping edge wins: no pulse, statistics cleared.
    for (int v = 3; v <= 15; v++) apply(v, 1'b0);
    apply(0, 1'b1);
    check_model("clrwrap");
    chk("clrwrap.pulse", int'(wrap_pulse), 0);
    chk("clrwrap.cnt", int'(wrap_cnt), 0);

    // clr on a faulting edge wins: no fault.
    for (int v = 1; v <= 3; v++) apply(v, 1'b0);
    apply(9, 1'b1);
    check_model("clrfault");
    chk("clrfault.fault", int'(fault), 0);
    chk("clrfault.expected", int'(expected), 10);

    // Stuck value while tracking is a fault.
    apply(10, 1'b0);
    apply(11, 1'b0);
    apply(11, 1'b0);
    check_model("stuck");
    chk("stuck.fault", int'(fault), 1);
    chk("stuck.fault_count", int'(fault_count), 11);
    apply(9, 1'b1);

    // Saturation: 300 wraps while locked.
    apply(10, 1'b0);
    apply(11, 1'b0);
    pulses = 0;
    for (int i = 0; i < 300 * 16; i++) begin
      apply((12 + i) % 16, 1'b0);
      check_model("sat");
      pulses += int'(wrap_pulse);
    end
    chk("sat.pulses", pulses, 300);
    chk("sat.cnt", int'(wrap_cnt), 255);

    // Async reset between edges while tracking with three wraps counted.
    apply(0, 1'b1);
    apply(1, 1'b0);
    apply(2, 1'b0);
    for (int i = 0; i < 46; i++) apply((3 + i) % 16, 1'b0);
    chk("pre_rst.cnt", int'(wrap_cnt), 3);
    chk("pre_rst.sync", int'(in_sync), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("arst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    apply(5, 1'b0);
    apply(6, 1'b0);
    chk("arst.sync1", int'(in_sync), 0);
    apply(7, 1'b0);
    chk("arst.sync2", int'(in_sync), 1);
    check_model("arst.resume");

    // Random: mostly good steps, with jumps, zeros and clears mixed in.
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 78)      apply((int'(count) + 1) % 16, 1'b0);
      else if (r < 86) apply(0, 1'b0);
      else if (r < 95) apply(int'($urandom_range(0, 15)), 1'b0);
      else             apply(int'($urandom_range(0, 15)), 1'b1);
      check_model("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/count_sequence_checker.md
Name: count_sequence_checker

Overview:
- Downstream monitor that consumes the free-running 4-bit binary counter output every clock.
- Checks that each sample is the previous sample +1, modulo 2^WIDTH.
- Counts wrap-arounds (max -> 0) and flags sequence faults.
- Used in lab bring-up to prove the counter stage on board and in simulation.

Parameters:
- WIDTH, 4: width of the monitored count.
- WRAP_W, 8: width of the wrap-around statistics counter.
- SYNC_LEN, 2: number of consecutive correct increments needed to declare lock.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset.
- count  input  WIDTH  counter value under test, sampled every posedge clk.
- clr  input  1  synchronous clear of the fault flag and statistics.
- in_sync  output  1  high while locked to a correct sequence.
- fault  output  1  sticky sequence-error flag.
- fault_count  output  WIDTH  offending sample captured at the first fault.
- expected  output  WIDTH  prev+1 mod 2^WIDTH; the value required at the next sample.
- wrap_pulse  output  1  one-cycle pulse per detected wrap.
- wrap_cnt  output  WRAP_W  saturating count of wraps.

Behaviour:
- Async reset (rst low), applied immediately without waiting for a clock edge:
  - state=ACQUIRE, prev=0, prev_valid=0, match=0.
  - in_sync=0, fault=0, fault_count=0, wrap_pulse=0, wrap_cnt=0, expected=1.
- Notation: "step ok" means count == prev+1 mod 2^WIDTH, using prev before the edge.
- Every edge with prev_valid=1 and clr=0 updates prev<=count. In FAULT, prev is frozen.
- The first edge after reset only captures prev and sets prev_valid=1; no check is made.
- expected is combinational from prev.
- ACQUIRE state:
  - step ok: match++.
  - Otherwise: match<=0.
  - When match reaches SYNC_LEN, go to TRACK. in_sync goes high on that same edge; latency is 1 edge after the SYNC_LEN-th correct sample.
- TRACK state:
  - step ok: stay in TRACK.
  - step ok with prev==2^WIDTH-1 (so count==0): wrap_pulse=1 for exactly one cycle; wrap_cnt++, saturating at 2^WRAP_W-1. wrap_pulse still fires when wrap_cnt is saturated.
  - count==0 with prev != max: upstream reset observed. Go to ACQUIRE with match=0 and in_sync=0. This is not a fault.
  - Any other mismatch, including a stuck value (count==prev): go to FAULT. fault=1, fault_count=count, in_sync=0, expected frozen at its value before the edge.
- FAULT state:
  - All inputs except clr are ignored.
  - fault, fault_count and expected hold.
- clr=1, any state, takes priority over all checks:
  - Clears fault, fault_count, wrap_cnt, wrap_pulse and match.
  - Sets state=ACQUIRE and in_sync=0.
  - prev<=count and prev_valid=1.
- clr coinciding with a wrap or a fault: clr wins; no pulse, no fault.
- Reset asserted mid-operation: outputs return to their reset values immediately, with no clock edge required.

Decomposition:
- Shared package holds:
  - state enum {ACQUIRE, TRACK, FAULT}.
  - Default constants CNT_W=4 and WRAP_W=8, shared with the counter stage.
- One natural sub-module: sat_counter (WRAP_W-bit saturating incrementer with sync clear), used for wrap_cnt.
- The FSM and compare logic stay in the top module.

Test Plan:
1. Acquire lock:
   - Stimulus: rst pulse, then count=0,1,2,3 on successive edges.
   - Required: in_sync=0 after the edges sampling 0 and 1; in_sync=1 after the edge sampling 2; fault=0 throughout; expected=4 after sampling 3.
2. Wrap detection:
   - Stimulus: locked, then feed 0..15 followed by 0.
   - Required: wrap_pulse=1 for exactly the one cycle after sampling that 0; wrap_cnt=1; in_sync stays 1.
3. Sequence fault:
   - Stimulus: locked on 5,6, then feed 9.
   - Required: fault=1, fault_count=9, expected=7 held, in_sync=0.
   - Then: feeding 10,11 changes nothing; clr for one cycle gives fault=0, wrap_cnt=0, state ACQUIRE; lock again after two correct steps.
4. Upstream reset:
   - Stimulus: locked, then feed 7,8,0.
   - Required: fault=0, in_sync=0 after sampling 0; continuing with 1,2 restores in_sync=1.
5. Saturation:
   - Stimulus: 300 full wraps while locked.
   - Required: wrap_cnt=255 and held there; wrap_pulse continues to pulse on every wrap.
6. Asynchronous reset:
   - Stimulus: drive rst low between clock edges while in TRACK with wrap_cnt=3.
   - Required: all outputs reach reset values before the next edge (expected=1); after rst is released, lock resumes after SYNC_LEN correct steps.
